// File: rtl/serial_comp_pkg.sv
// serial_comp_pkg: shared types for the serial magnitude comparator.
//   state_t  - controller states (idle, running digits, result presented)
//   result_t - packed {eq, gt, lt} comparison result
package serial_comp_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    typedef struct packed {
        logic eq;
        logic gt;
        logic lt;
    } result_t;

    localparam result_t RESULT_CLR = '{eq: 1'b0, gt: 1'b0, lt: 1'b0};

endpackage

// File: rtl/serial_comp_digit_comp.sv
// digit_comp: combinational DIGIT-bit unsigned magnitude compare.
// Ports:
//   a, b        in  DIGIT  digits to compare
//   eq, gt, lt  out 1      a == b, a > b, a < b (exactly one is high)
module digit_comp #(
    parameter int DIGIT = 2
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    output logic             eq,
    output logic             gt,
    output logic             lt
);

    always_comb begin
        eq = (a == b);
        gt = (a > b);
        lt = (a < b);
    end

endmodule

// File: rtl/serial_comp.sv
// serial_comp: multi-cycle MSB-first magnitude comparator, DIGIT bits/clock,
// unsigned or two's-complement, with start/busy/done handshake.
// Optional feature: define SERIAL_COMP_EARLY_EXIT_EN to leave S_RUN on the
// first differing digit (data-dependent latency); otherwise latency is N.
// Ports:
//   clk        in  1      rising-edge clock
//   reset      in  1      synchronous active-high reset (aborts any operation)
//   start      in  1      request, accepted when busy == 0
//   a, b       in  WIDTH  operands, sampled on accepted start
//   is_signed  in  1      1 = two's complement, sampled on accepted start
//   busy       out 1      high while digits are processed
//   done       out 1      one-cycle pulse, flags valid
//   eq, gt, lt out 1      comparison result, held until next accepted start
module serial_comp
    import serial_comp_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             is_signed,
    output logic             busy,
    output logic             done,
    output logic             eq,
    output logic             gt,
    output logic             lt
);

    if ((WIDTH < 2) || (DIGIT < 1) || (DIGIT > WIDTH) || ((WIDTH % DIGIT) != 0)) begin : g_bad_params
        $error("serial_comp: illegal WIDTH/DIGIT combination");
    end

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = $clog2(N + 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    result_t          res_q, res_d;

    logic             dig_eq, dig_gt, dig_lt;
    logic             decided;
    logic [WIDTH-1:0] msb_flip;

    digit_comp #(
        .DIGIT(DIGIT)
    ) u_digit_comp (
        .a  (a_q[WIDTH-1 -: DIGIT]),
        .b  (b_q[WIDTH-1 -: DIGIT]),
        .eq (dig_eq),
        .gt (dig_gt),
        .lt (dig_lt)
    );

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        cnt_d    = cnt_q;
        res_d    = res_q;
        decided  = res_q.gt | res_q.lt;
        // Inverting the sign bit maps two's complement onto offset binary,
        // so the unsigned digit compare orders signed values correctly.
        msb_flip = {is_signed, {(WIDTH-1){1'b0}}};

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    a_d     = a ^ msb_flip;
                    b_d     = b ^ msb_flip;
                    cnt_d   = CW'(N);
                    res_d   = RESULT_CLR;
                    state_d = S_RUN;
                end else if (state_q == S_DONE) begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                a_d   = a_q << DIGIT;
                b_d   = b_q << DIGIT;
                cnt_d = cnt_q - CW'(1);
                // Only the first differing digit decides; later ones are ignored.
                if (!decided) begin
                    res_d.gt = dig_gt;
                    res_d.lt = dig_lt;
                end
                if (cnt_q == CW'(1)) begin
                    state_d  = S_DONE;
                    res_d.eq = !decided && dig_eq;
                end
`ifdef SERIAL_COMP_EARLY_EXIT_EN
                if (!decided && !dig_eq) begin
                    state_d = S_DONE;
                end
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            res_q   <= RESULT_CLR;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
        end
    end

    assign busy = (state_q == S_RUN);
    assign done = (state_q == S_DONE);
    assign eq   = res_q.eq;
    assign gt   = res_q.gt;
    assign lt   = res_q.lt;

endmodule

// File: tb/tb_serial_comp.sv
// Self-checking bench for serial_comp: directed 8-bit/2-bit-digit scenarios
// plus exhaustive 4-bit checks with DIGIT=1 and DIGIT=2, scoreboard style.
module tb_serial_comp;

`ifdef SERIAL_COMP_EARLY_EXIT_EN
    localparam bit EE = 1'b1;
`else
    localparam bit EE = 1'b0;
`endif

    typedef struct {
        logic [2:0] flags;     // {eq, gt, lt}
        int         done_cyc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       rst;
    logic       start8, s8;
    logic [7:0] a8, b8;
    logic       busy8, done8, eq8, gt8, lt8;
    logic       start4, s4;
    logic [3:0] a4, b4;
    logic       busy1, done1, eq1, gt1, lt1;
    logic       busy2, done2, eq2, gt2, lt2;

    exp_t q8[$], q1[$], q2[$];
    exp_t e8, e1, e2;

    serial_comp #(.WIDTH(8), .DIGIT(2)) u8 (
        .clk(clk), .reset(rst), .start(start8), .a(a8), .b(b8), .is_signed(s8),
        .busy(busy8), .done(done8), .eq(eq8), .gt(gt8), .lt(lt8)
    );
    serial_comp #(.WIDTH(4), .DIGIT(1)) u41 (
        .clk(clk), .reset(rst), .start(start4), .a(a4), .b(b4), .is_signed(s4),
        .busy(busy1), .done(done1), .eq(eq1), .gt(gt1), .lt(lt1)
    );
    serial_comp #(.WIDTH(4), .DIGIT(2)) u42 (
        .clk(clk), .reset(rst), .start(start4), .a(a4), .b(b4), .is_signed(s4),
        .busy(busy2), .done(done2), .eq(eq2), .gt(gt2), .lt(lt2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic score(input string nm, input exp_t e, input logic [2:0] f, input logic busy);
        chk({nm, "_flags"}, 32'(f), 32'(e.flags));
        chk({nm, "_latency"}, cyc, e.done_cyc);
        chk({nm, "_busy_in_done"}, 32'(busy), 32'd0);
    endtask

    // Monitors: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) if (done8 === 1'b1) begin
        if (q8.size() == 0) chk("w8_unexpected_done", 32'(q8.size()), 32'd1);
        else begin e8 = q8.pop_front(); score("w8", e8, {eq8, gt8, lt8}, busy8); end
    end
    always @(negedge clk) if (done1 === 1'b1) begin
        if (q1.size() == 0) chk("x1_unexpected_done", 32'(q1.size()), 32'd1);
        else begin e1 = q1.pop_front(); score("x1", e1, {eq1, gt1, lt1}, busy1); end
    end
    always @(negedge clk) if (done2 === 1'b1) begin
        if (q2.size() == 0) chk("x2_unexpected_done", 32'(q2.size()), 32'd1);
        else begin e2 = q2.pop_front(); score("x2", e2, {eq2, gt2, lt2}, busy2); end
    end

    // k = 1-based index of the first differing digit, used under early exit.
    task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic s,
                          input logic [2:0] f, input int k);
        exp_t e;
        a8 = a; b8 = b; s8 = s; start8 = 1'b1;
        e.flags    = f;
        e.done_cyc = cyc + 1 + (EE ? k : 4);
        q8.push_back(e);
    endtask

    task automatic wait8(input string name);
        for (int i = 0; i < 40 && q8.size() != 0; i++) @(negedge clk);
        if (q8.size() != 0) begin
            chk({name, "_timeout"}, 32'(q8.size()), 32'd0);
            q8.delete();
        end
    endtask

    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic s,
                       input logic [2:0] f, input int k, input string name);
        @(posedge clk); #1 issue8(a, b, s, f, k);
        @(posedge clk); #1 start8 = 1'b0;
        chk({name, "_busy"}, 32'(busy8), 32'd1);
        wait8(name);
    endtask

    function automatic logic [2:0] ref4(input logic [3:0] a, input logic [3:0] b, input logic s);
        int ia, ib;
        ia = int'(a);
        ib = int'(b);
        if (s && a[3]) ia -= 16;
        if (s && b[3]) ib -= 16;
        return {ia == ib, ia > ib, ia < ib};
    endfunction

    function automatic int kdiff(input logic [3:0] a, input logic [3:0] b, input logic s, input int d);
        logic [3:0] x, y;
        x = a; y = b;
        if (s) begin x[3] = ~x[3]; y[3] = ~y[3]; end
        for (int i = 0; i < 4 / d; i++)
            if ((x >> (4 - (i + 1) * d)) != (y >> (4 - (i + 1) * d))) return i + 1;
        return 4 / d;
    endfunction

    task automatic issue4(input logic [3:0] a, input logic [3:0] b, input logic s);
        exp_t e;
        a4 = a; b4 = b; s4 = s; start4 = 1'b1;
        e.flags    = ref4(a, b, s);
        e.done_cyc = cyc + 1 + (EE ? kdiff(a, b, s, 1) : 4);
        q1.push_back(e);
        e.done_cyc = cyc + 1 + (EE ? kdiff(a, b, s, 2) : 2);
        q2.push_back(e);
    endtask

    int ex_fail;

    initial begin
        rst = 1'b1;
        start8 = 1'b0; a8 = '0; b8 = '0; s8 = 1'b0;
        start4 = 1'b0; a4 = '0; b4 = '0; s4 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", 32'(busy8), 32'd0);
        chk("reset_done", 32'(done8), 32'd0);
        chk("reset_flags", 32'({eq8, gt8, lt8}), 32'd0);
        chk("reset_busy4", 32'({busy1, busy2}), 32'd0);
        rst = 1'b0;

        // Equal operands, then flags must hold while idle.
        op8(8'h5A, 8'h5A, 1'b0, 3'b100, 4, "equal");
        repeat (3) @(posedge clk);
        #1;
        chk("hold_flags", 32'({eq8, gt8, lt8}), 32'b100);
        chk("hold_busy", 32'(busy8), 32'd0);
        chk("hold_done", 32'(done8), 32'd0);

        op8(8'h80, 8'h7F, 1'b0, 3'b010, 1, "unsigned_gt");
        op8(8'h80, 8'h7F, 1'b1, 3'b001, 1, "signed_lt");
        op8(8'hFF, 8'hFE, 1'b1, 3'b010, 4, "signed_gt");

        // Back-to-back with a start pulse and operand changes during busy.
        @(posedge clk); #1 issue8(8'h12, 8'h34, 1'b0, 3'b001, 2);
        @(posedge clk); #1 a8 = 8'hFF; b8 = 8'h00; s8 = 1'b1;
        @(posedge clk); #1 start8 = 1'b0; a8 = 8'h77; b8 = 8'h11;
        for (int i = 0; i < 20 && done8 !== 1'b1; i++) @(negedge clk);
        chk("b2b_first_done", 32'(done8), 32'd1);
        issue8(8'h03, 8'h09, 1'b0, 3'b001, 3);
        @(posedge clk); #1;
        chk("b2b_busy", 32'(busy8), 32'd1);
        chk("b2b_flags_cleared", 32'({eq8, gt8, lt8}), 32'd0);
        start8 = 1'b0;
        wait8("b2b");

        // Reset during the second S_RUN cycle aborts with no done pulse.
        @(posedge clk); #1 a8 = 8'h3C; b8 = 8'h3C; s8 = 1'b0; start8 = 1'b1;
        @(posedge clk); #1 start8 = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_busy", 32'(busy8), 32'd0);
        chk("abort_flags", 32'({eq8, gt8, lt8}), 32'd0);
        chk("abort_done", 32'(done8), 32'd0);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        chk("abort_no_done", 32'(done8), 32'd0);
        op8(8'h01, 8'h02, 1'b0, 3'b001, 4, "post_reset");

        // Exhaustive 4-bit, both digit sizes, both modes.
        ex_fail = failures;
        for (int s = 0; s < 2; s++)
            for (int a = 0; a < 16; a++)
                for (int b = 0; b < 16; b++) begin
                    @(posedge clk); #1 issue4(4'(a), 4'(b), s[0]);
                    @(posedge clk); #1 start4 = 1'b0;
                    for (int i = 0; i < 20 && (q1.size() != 0 || q2.size() != 0); i++) @(negedge clk);
                    if (q1.size() != 0 || q2.size() != 0) begin
                        chk("x_timeout", 32'(q1.size() + q2.size()), 32'd0);
                        q1.delete(); q2.delete();
                    end
                end
        $display("exhaustive 4-bit: pairs=512 per digit size, errors=%0d", failures - ex_fail);

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
